// File: rtl/spad_pkg.sv
// Shared types for the scratchpad stream controller.
//   spad_state_e : controller FSM states
//   OP_READ/WRITE: cmd_op encodings (READ = bank->PE, WRITE = PE->bank)
package spad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } spad_state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/spad_bank.sv
// Single-port synchronous SRAM bank, one access per cycle.
//   clk   : rising-edge clock
//   en    : access enable
//   we    : 1 = write wdata at addr, 0 = read addr
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access; held otherwise
module spad_bank #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/spad_stream_ctrl.sv
// Banked scratchpad with a command-driven stream engine towards the PE array.
//   clk, reset            : clock, synchronous active-low reset
//   cmd_*                 : valid/ready command (op, base, len, bank mask)
//   busy, done            : command in progress / one-cycle completion pulse
//   pe_out_*              : READ beats to the PE lanes (valid/ready, data, lane mask)
//   pe_in_*               : WRITE beats from the PE lanes (valid/ready, data)
//   host_*                : single-word host access, honoured only in IDLE
//   host_err              : pulse the cycle after a host access was dropped
module spad_stream_ctrl
    import spad_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_BANKS  = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_op,
    input  logic [ADDR_WIDTH-1:0]           cmd_base,
    input  logic [ADDR_WIDTH:0]             cmd_len,
    input  logic [NUM_BANKS-1:0]            cmd_bank_mask,
    output logic                            busy,
    output logic                            done,
    output logic                            pe_out_valid,
    input  logic                            pe_out_ready,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] pe_out_data,
    output logic [NUM_BANKS-1:0]            pe_out_lmask,
    input  logic                            pe_in_valid,
    output logic                            pe_in_ready,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] pe_in_data,
    input  logic                            host_wr_en,
    input  logic                            host_rd_en,
    input  logic [$clog2(NUM_BANKS)-1:0]    host_bank,
    input  logic [ADDR_WIDTH-1:0]           host_addr,
    input  logic [DATA_WIDTH-1:0]           host_wdata,
    output logic [DATA_WIDTH-1:0]           host_rdata,
    output logic                            host_err
);

    localparam int unsigned BW = $clog2(NUM_BANKS);
    localparam int unsigned LW = ADDR_WIDTH + 1;
    localparam int unsigned VW = NUM_BANKS * DATA_WIDTH;
    localparam logic [LW-1:0]         LEN_ONE  = LW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    spad_state_e           state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LW-1:0]         issue_left_q;   // reads still to issue
    logic [LW-1:0]         beats_left_q;   // handshakes still to complete
    logic [NUM_BANKS-1:0]  mask_q;
    logic                  busy_q, done_q, cmd_ready_q, host_err_q;

    // Read pipeline: one read in flight in the bank, plus a 2-entry skid (entry 0 = head).
    logic                  rd_pend_q;
    logic [1:0]            sk_cnt_q;
    logic [VW-1:0]         sk_data_q [2];

    logic                  host_rd_q;
    logic [BW-1:0]         host_bank_q;

    logic                  bank_en    [NUM_BANKS];
    logic                  bank_we    [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] bank_addr  [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [VW-1:0]         rd_lanes;

    logic       host_req, host_ok, issue, out_hs, wr_hs, push, pop;
    logic [1:0] inflight;

    assign host_req = host_wr_en | host_rd_en;
    // A command offered in IDLE takes priority; the host access is then dropped.
    assign host_ok  = (state_q == ST_IDLE) & ~cmd_valid;
    assign inflight = sk_cnt_q + {1'b0, rd_pend_q};
    assign issue    = (state_q == ST_READ) & (issue_left_q != '0) & (inflight < 2'd2);

    assign pe_out_valid = (sk_cnt_q != 2'd0) | rd_pend_q;
    assign out_hs       = pe_out_valid & pe_out_ready;
    // Bank data bypasses the skid when it is empty; otherwise it queues behind the head.
    assign pop  = out_hs & (sk_cnt_q != 2'd0);
    assign push = rd_pend_q & ((sk_cnt_q != 2'd0) | ~pe_out_ready);

    assign pe_in_ready = (state_q == ST_WRITE);
    assign wr_hs       = pe_in_valid & pe_in_ready;

    assign pe_out_data  = !pe_out_valid ? '0 : (sk_cnt_q != 2'd0) ? sk_data_q[0] : rd_lanes;
    assign pe_out_lmask = pe_out_valid ? mask_q : '0;
    assign host_rdata   = host_rd_q ? bank_rdata[host_bank_q] : '0;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cmd_ready    = cmd_ready_q;
    assign host_err     = host_err_q;

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_en[i]    = 1'b0;
            bank_we[i]    = 1'b0;
            bank_addr[i]  = addr_q;
            bank_wdata[i] = pe_in_data[i*DATA_WIDTH +: DATA_WIDTH];
            if (state_q == ST_READ) begin
                bank_en[i] = issue & mask_q[i];
            end else if (state_q == ST_WRITE) begin
                bank_en[i] = wr_hs & mask_q[i];
                bank_we[i] = wr_hs & mask_q[i];
            end else if (host_ok && host_req && host_bank == BW'(i)) begin
                bank_en[i]    = 1'b1;
                bank_we[i]    = host_wr_en;
                bank_addr[i]  = host_addr;
                bank_wdata[i] = host_wdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        spad_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[g]),
            .we    (bank_we[g]),
            .addr  (bank_addr[g]),
            .wdata (bank_wdata[g]),
            .rdata (bank_rdata[g])
        );
        // Unmasked lanes carry stale bank output, so force them to zero.
        assign rd_lanes[g*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[g] & {DATA_WIDTH{mask_q[g]}};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            beats_left_q <= '0;
            mask_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            host_err_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            sk_cnt_q     <= 2'd0;
            host_rd_q    <= 1'b0;
            host_bank_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            host_err_q  <= host_req & ~host_ok;
            host_rd_q   <= host_ok & host_rd_en & ~host_wr_en;
            host_bank_q <= host_bank;
            rd_pend_q   <= issue;

            if (pop && push) begin
                sk_data_q[0] <= rd_lanes;
            end else if (pop) begin
                sk_data_q[0] <= sk_data_q[1];
            end else if (push) begin
                if (sk_cnt_q == 2'd0) sk_data_q[0] <= rd_lanes;
                else                  sk_data_q[1] <= rd_lanes;
            end
            if (push && !pop)      sk_cnt_q <= sk_cnt_q + 2'd1;
            else if (pop && !push) sk_cnt_q <= sk_cnt_q - 2'd1;

            if (issue || wr_hs) addr_q <= addr_q + ADDR_ONE;
            if (issue) issue_left_q <= issue_left_q - LEN_ONE;

            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q       <= cmd_base;
                        issue_left_q <= cmd_len;
                        beats_left_q <= cmd_len;
                        mask_q       <= cmd_bank_mask;
                        busy_q       <= 1'b1;
                        cmd_ready_q  <= 1'b0;
                        if (cmd_len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= (cmd_op == OP_WRITE) ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_READ, ST_WRITE: begin
                    if ((state_q == ST_READ) ? out_hs : wr_hs) begin
                        beats_left_q <= beats_left_q - LEN_ONE;
                        if (beats_left_q == LEN_ONE) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spad_stream_ctrl.sv
module tb_spad_stream_ctrl;

    localparam int DW = 16;
    localparam int NB = 8;
    localparam int AW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready, cmd_op;
    logic [AW-1:0]     cmd_base;
    logic [AW:0]       cmd_len;
    logic [NB-1:0]     cmd_bank_mask;
    logic              busy, done;
    logic              pe_out_valid, pe_out_ready;
    logic [NB*DW-1:0]  pe_out_data;
    logic [NB-1:0]     pe_out_lmask;
    logic              pe_in_valid, pe_in_ready;
    logic [NB*DW-1:0]  pe_in_data;
    logic              host_wr_en, host_rd_en;
    logic [2:0]        host_bank;
    logic [AW-1:0]     host_addr;
    logic [DW-1:0]     host_wdata, host_rdata;
    logic              host_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spad_stream_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_BANKS  (NB),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_base      (cmd_base),
        .cmd_len       (cmd_len),
        .cmd_bank_mask (cmd_bank_mask),
        .busy          (busy),
        .done          (done),
        .pe_out_valid  (pe_out_valid),
        .pe_out_ready  (pe_out_ready),
        .pe_out_data   (pe_out_data),
        .pe_out_lmask  (pe_out_lmask),
        .pe_in_valid   (pe_in_valid),
        .pe_in_ready   (pe_in_ready),
        .pe_in_data    (pe_in_data),
        .host_wr_en    (host_wr_en),
        .host_rd_en    (host_rd_en),
        .host_bank     (host_bank),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_rdata    (host_rdata),
        .host_err      (host_err)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input int b, input int a, input logic [15:0] d);
        host_wr_en = 1'b1;
        host_bank  = 3'(b);
        host_addr  = 8'(a);
        host_wdata = d;
        tick();
        host_wr_en = 1'b0;
    endtask

    task automatic host_read(input string tag, input int b, input int a, input logic [15:0] exp);
        host_rd_en = 1'b1;
        host_bank  = 3'(b);
        host_addr  = 8'(a);
        tick();
        host_rd_en = 1'b0;
        check(tag, 128'(host_rdata), 128'(exp));
    endtask

    // Leaves the bench in cycle T+1 (T = acceptance cycle).
    task automatic issue_cmd(input logic op, input int base, input int len, input logic [7:0] m);
        cmd_valid     = 1'b1;
        cmd_op        = op;
        cmd_base      = 8'(base);
        cmd_len       = 9'(len);
        cmd_bank_mask = m;
        check("cmd_ready_idle", 128'(cmd_ready), 128'(1));
        tick();
        cmd_valid = 1'b0;
    endtask

    // Preloaded pattern: bank b, address a holds 16'h1000 + 8b + a.
    function automatic logic [127:0] pre_vec(input int a, input logic [7:0] m);
        logic [127:0] v;
        v = '0;
        for (int b = 0; b < NB; b++)
            if (m[b]) v[b*DW +: DW] = 16'h1000 + 16'(8*b + a);
        return v;
    endfunction

    initial begin
        logic [127:0] exp_v, held;
        logic         stalled, done_seen;
        int           k;

        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
        cmd_bank_mask = '0; pe_out_ready = 1'b0; pe_in_valid = 1'b0; pe_in_data = '0;
        host_wr_en = 1'b0; host_rd_en = 1'b0; host_bank = '0; host_addr = '0; host_wdata = '0;
        tick(); tick(); tick();

        // Reset state
        check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_out_valid", 128'(pe_out_valid), 128'(0));
        check("rst_out_data", pe_out_data, 128'(0));
        check("rst_lmask", 128'(pe_out_lmask), 128'(0));
        check("rst_in_ready", 128'(pe_in_ready), 128'(0));
        check("rst_host_err", 128'(host_err), 128'(0));
        check("rst_host_rdata", 128'(host_rdata), 128'(0));
        reset = 1'b1;
        tick();

        // 1: preload, then full-rate READ
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 4; a++)
                host_write(b, a, 16'h1000 + 16'(8*b + a));
        host_read("t1_host_rd_b5a2", 5, 2, 16'h102A);

        pe_out_ready = 1'b1;
        issue_cmd(1'b0, 0, 4, 8'hFF);
        check("t1_busy", 128'(busy), 128'(1));
        check("t1_valid_t1", 128'(pe_out_valid), 128'(0));
        for (int b = 0; b < 4; b++) begin
            tick();
            check("t1_valid", 128'(pe_out_valid), 128'(1));
            check("t1_data", pe_out_data, pre_vec(b, 8'hFF));
            check("t1_lmask", 128'(pe_out_lmask), 128'(8'hFF));
            check("t1_no_done", 128'(done), 128'(0));
        end
        tick();
        check("t1_done", 128'(done), 128'(1));
        check("t1_valid_after", 128'(pe_out_valid), 128'(0));
        check("t1_busy_done", 128'(busy), 128'(1));
        tick();
        check("t1_done_pulse", 128'(done), 128'(0));
        check("t1_idle_busy", 128'(busy), 128'(0));
        check("t1_idle_ready", 128'(cmd_ready), 128'(1));

        // 2: READ under backpressure 1,0,0,1,0,0,...
        issue_cmd(1'b0, 0, 4, 8'hFF);
        k = 0; stalled = 1'b0; done_seen = 1'b0; held = '0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            pe_out_ready = (c % 3 == 0);
            if (stalled) begin
                check("t2_hold_valid", 128'(pe_out_valid), 128'(1));
                check("t2_hold_data", pe_out_data, held);
            end
            if (done) begin
                done_seen = 1'b1;
            end else if (pe_out_valid) begin
                if (pe_out_ready) begin
                    check("t2_beat", pe_out_data, pre_vec(k, 8'hFF));
                    k++;
                    stalled = 1'b0;
                end else begin
                    held    = pe_out_data;
                    stalled = 1'b1;
                end
            end
            if (!done_seen) tick();
        end
        check("t2_beat_count", 128'(k), 128'(4));
        check("t2_done_seen", 128'(done_seen), 128'(1));
        pe_out_ready = 1'b1;
        tick();

        // 3: WRITE across the address wrap, banks 0 and 2 only
        issue_cmd(1'b1, 8'hFE, 4, 8'h05);
        pe_in_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int l = 0; l < NB; l++) pe_in_data[l*DW +: DW] = 16'hA000 + 16'(b);
            check("t3_in_ready", 128'(pe_in_ready), 128'(1));
            tick();
        end
        pe_in_valid = 1'b0;
        check("t3_done", 128'(done), 128'(1));
        check("t3_in_ready_off", 128'(pe_in_ready), 128'(0));
        tick();
        host_read("t3_b0_fe", 0, 8'hFE, 16'hA000);
        host_read("t3_b0_ff", 0, 8'hFF, 16'hA001);
        host_read("t3_b0_00", 0, 0, 16'hA002);
        host_read("t3_b2_01", 2, 1, 16'hA003);
        host_read("t3_b2_00", 2, 0, 16'hA002);
        host_read("t3_b1_00", 1, 0, 16'h1008);
        host_read("t3_b1_01", 1, 1, 16'h1009);
        // Stream the same window back: lanes 0/2 carry data, the rest stay zero
        issue_cmd(1'b0, 8'hFE, 4, 8'h05);
        for (int b = 0; b < 4; b++) begin
            tick();
            exp_v = '0;
            exp_v[0 +: DW]    = 16'hA000 + 16'(b);
            exp_v[2*DW +: DW] = 16'hA000 + 16'(b);
            check("t3_rd_data", pe_out_data, exp_v);
            check("t3_rd_lmask", 128'(pe_out_lmask), 128'(8'h05));
        end
        tick();
        check("t3_rd_done", 128'(done), 128'(1));
        tick();

        // 4: zero-length command; dropped host writes
        host_wr_en = 1'b1; host_bank = 3'd3; host_addr = 8'd1; host_wdata = 16'hBEEF;
        issue_cmd(1'b0, 0, 0, 8'hFF);
        check("t4_done", 128'(done), 128'(1));
        check("t4_err_cmd_wins", 128'(host_err), 128'(1));
        check("t4_no_valid", 128'(pe_out_valid), 128'(0));
        check("t4_no_in_ready", 128'(pe_in_ready), 128'(0));
        host_addr = 8'd0; host_wdata = 16'hDEAD;
        tick();
        host_wr_en = 1'b0;
        check("t4_err_busy", 128'(host_err), 128'(1));
        check("t4_done_off", 128'(done), 128'(0));
        check("t4_idle", 128'(busy), 128'(0));
        tick();
        check("t4_err_clear", 128'(host_err), 128'(0));
        host_read("t4_b3_00", 3, 0, 16'h1018);
        host_read("t4_b3_01", 3, 1, 16'h1019);

        // 5: reset during a len=8 READ, then a fresh command
        issue_cmd(1'b0, 0, 8, 8'hFF);
        tick(); tick(); tick(); tick();
        check("t5_mid_valid", 128'(pe_out_valid), 128'(1));
        check("t5_mid_data", pe_out_data, pre_vec(3, 8'hFF));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t5_rst_busy", 128'(busy), 128'(0));
        check("t5_rst_ready", 128'(cmd_ready), 128'(1));
        check("t5_rst_valid", 128'(pe_out_valid), 128'(0));
        check("t5_rst_done", 128'(done), 128'(0));
        tick();
        check("t5_no_done", 128'(done), 128'(0));
        check("t5_still_idle", 128'(pe_out_valid), 128'(0));
        issue_cmd(1'b0, 2, 2, 8'h81);
        for (int b = 0; b < 2; b++) begin
            tick();
            check("t5_new_valid", 128'(pe_out_valid), 128'(1));
            check("t5_new_data", pe_out_data, pre_vec(2 + b, 8'h81));
        end
        tick();
        check("t5_new_done", 128'(done), 128'(1));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
